// File: rtl/load_store_unit.sv
// load_store_unit: data-memory access stage for the RV32I core.
//
// Takes the decoded load/store strobes, funct3, the ALU effective address and
// rs2. It runs one valid/ready transaction to data memory and returns an
// aligned, extended load result. Stall is held while an access is outstanding.
//
// Ports:
//   clk_i, rst_ni          core clock, synchronous active-low reset
//   load_i, store_i        decoded load / store strobes
//   fun3_i                 funct3 (access size and signedness)
//   addr_i                 effective address
//   store_data_i           rs2 value
//   mem_req_o .. mem_wstrb_o   request to data memory (word address, lane data)
//   mem_ready_i, mem_rdata_i   memory handshake and read data
//   stall_o                hold PC / instruction
//   load_data_o            extended load result, held until the next load
//   done_o                 completion pulse
//   misaligned_o, illegal_o, bus_err_o   one-cycle exception pulses

module load_store_unit #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              store_i,
    input  logic [2:0]        fun3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       store_data_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_wstrb_o,
    input  logic              mem_ready_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              stall_o,
    output logic [31:0]       load_data_o,
    output logic              done_o,
    output logic              misaligned_o,
    output logic              illegal_o,
    output logic              bus_err_o
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e              state_q;
    logic [CntW-1:0]     cnt_q;
    logic [2:0]          fun3_q;
    logic [1:0]          off_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic [3:0]          mem_wstrb_q;
    logic [31:0]         load_data_q;
    logic                done_q;
    logic                misaligned_q;
    logic                illegal_q;
    logic                bus_err_q;

    logic                op_illegal;
    logic                op_misaligned;
    logic                op_issue;
    logic [31:0]         wdata_d;
    logic [3:0]          wstrb_d;
    logic [31:0]         lane;
    logic [31:0]         ext_data;

    // Issue decode: illegal takes priority over misalignment.
    always_comb begin
        op_illegal    = 1'b0;
        op_misaligned = 1'b0;
        if (load_i && store_i) begin
            op_illegal = 1'b1;
        end else if (load_i) begin
            op_illegal = (fun3_i == 3'b011) || (fun3_i[2:1] == 2'b11);
        end else if (store_i) begin
            op_illegal = (fun3_i >= 3'b011);
        end

        case (fun3_i[1:0])
            2'b01:   op_misaligned = addr_i[0];
            2'b10:   op_misaligned = (addr_i[1:0] != 2'b00);
            default: op_misaligned = 1'b0;
        endcase
        op_misaligned = op_misaligned && (load_i || store_i) && !op_illegal;
        op_issue      = (load_i || store_i) && !op_illegal && !op_misaligned;
    end

    // Store lane replication and byte enables.
    always_comb begin
        case (fun3_i[1:0])
            2'b00: begin
                wdata_d = {4{store_data_i[7:0]}};
                wstrb_d = 4'b0001 << addr_i[1:0];
            end
            2'b01: begin
                wdata_d = {2{store_data_i[15:0]}};
                wstrb_d = 4'b0011 << {addr_i[1], 1'b0};
            end
            default: begin
                wdata_d = store_data_i;
                wstrb_d = 4'b1111;
            end
        endcase
    end

    // Load lane select and extension; word loads are aligned so the shift is 0.
    always_comb begin
        lane = mem_rdata_i >> {off_q, 3'b000};
        case (fun3_q)
            3'b000:  ext_data = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ext_data = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ext_data = {24'h000000, lane[7:0]};
            3'b101:  ext_data = {16'h0000, lane[15:0]};
            default: ext_data = lane;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            fun3_q       <= 3'b000;
            off_q        <= 2'b00;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
            mem_wstrb_q  <= 4'b0000;
            load_data_q  <= 32'h0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            illegal_q    <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            illegal_q    <= 1'b0;
            bus_err_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    misaligned_q <= op_misaligned;
                    illegal_q    <= op_illegal;
                    if (op_issue) begin
                        state_q     <= StAccess;
                        cnt_q       <= '0;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= store_i;
                        mem_addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
                        mem_wdata_q <= wdata_d;
                        mem_wstrb_q <= store_i ? wstrb_d : 4'b0000;
                        fun3_q      <= fun3_i;
                        off_q       <= addr_i[1:0];
                    end
                end
                StAccess: begin
                    if (mem_req_q && mem_ready_i) begin
                        if (!mem_we_q) begin
                            load_data_q <= ext_data;
                        end
                        state_q     <= StDone;
                        done_q      <= 1'b1;
                        cnt_q       <= '0;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_wstrb_q <= 4'b0000;
                    end else if ((TIMEOUT != 0) && (32'(cnt_q) + 32'd1 == TIMEOUT)) begin
                        state_q     <= StIdle;
                        bus_err_q   <= 1'b1;
                        cnt_q       <= '0;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_wstrb_q <= 4'b0000;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    // PC advances at this edge; the next op is seen next cycle.
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign stall_o      = (state_q == StAccess) || ((state_q == StIdle) && op_issue);
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_wstrb_o  = mem_wstrb_q;
    assign load_data_o  = load_data_q;
    assign done_o       = done_q;
    assign misaligned_o = misaligned_q;
    assign illegal_o    = illegal_q;
    assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed vector table, timeout and reset
// sequences, then randomized operations checked against a behavioural model.

module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic        store;
    logic [2:0]  fun3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall;
    logic [31:0] load_data;
    logic        done;
    logic        misaligned;
    logic        illegal;
    logic        bus_err;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_ld = 32'h0;

    load_store_unit #(
        .TIMEOUT (4),
        .ADDR_W  (32)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .load_i       (load),
        .store_i      (store),
        .fun3_i       (fun3),
        .addr_i       (addr),
        .store_data_i (store_data),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_wstrb_o  (mem_wstrb),
        .mem_ready_i  (mem_ready),
        .mem_rdata_i  (mem_rdata),
        .stall_o      (stall),
        .load_data_o  (load_data),
        .done_o       (done),
        .misaligned_o (misaligned),
        .illegal_o    (illegal),
        .bus_err_o    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = performs an access, 1 = misaligned, 2 = illegal
    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          wait_n;
        int          kind;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] ld_data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model, computed from the ISA rules with plain arithmetic.
    function automatic int model_kind(logic ld, logic st, logic [2:0] f3, logic [31:0] a);
        int f;
        int size;
        f = int'(f3);
        if (ld && st) return 2;
        if (ld && (f == 3 || f == 6 || f == 7)) return 2;
        if (st && f >= 3) return 2;
        size = 1 << (f % 4);
        if (int'(a % 4) % size != 0) return 1;
        return 0;
    endfunction

    function automatic logic [3:0] model_wstrb(logic [2:0] f3, logic [31:0] a);
        int off;
        off = int'(a % 4);
        if (f3 == 3'd0) return 4'(1 << off);
        if (f3 == 3'd1) return 4'(3 << (off - off % 2));
        return 4'd15;
    endfunction

    function automatic logic [31:0] model_wdata(logic [2:0] f3, logic [31:0] sd);
        if (f3 == 3'd0) return (sd % 256) * 32'h01010101;
        if (f3 == 3'd1) return (sd % 65536) * 32'h00010001;
        return sd;
    endfunction

    function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a, logic [31:0] rd);
        logic [31:0] lane;
        longint      v;
        lane = rd >> (8 * (a % 4));
        case (f3)
            3'd0: begin v = longint'(lane % 256);   if (v >= 128)   v -= 256;   end
            3'd1: begin v = longint'(lane % 65536); if (v >= 32768) v -= 65536; end
            3'd4: v = longint'(lane % 256);
            3'd5: v = longint'(lane % 65536);
            default: v = longint'(rd);
        endcase
        return 32'(v);
    endfunction

    // Called just after a rising edge with the DUT idle.
    task automatic run_op(input vec_t v);
        load       = v.ld;
        store      = v.st;
        fun3       = v.f3;
        addr       = v.addr;
        store_data = v.sdata;
        mem_ready  = 1'b0;
        @(negedge clk);
        chk("issue_stall", 32'(stall), 32'(v.kind == 0));
        chk("issue_no_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        load  = 1'b0;
        store = 1'b0;
        if (v.kind == 0) begin
            for (int k = 0; k <= v.wait_n; k++) begin
                mem_ready = (k == v.wait_n);
                mem_rdata = (k == v.wait_n) ? v.rdata : $urandom;
                @(negedge clk);
                chk("acc_req", 32'(mem_req), 32'd1);
                chk("acc_stall", 32'(stall), 32'd1);
                chk("acc_done", 32'(done), 32'd0);
                chk("acc_addr", mem_addr, {v.addr[31:2], 2'b00});
                chk("acc_we", 32'(mem_we), 32'(v.st));
                chk("acc_wstrb", 32'(mem_wstrb), 32'(v.wstrb));
                if (v.st) chk("acc_wdata", mem_wdata, v.wdata);
                @(posedge clk); #1;
            end
            mem_ready = 1'b0;
            @(negedge clk);
            chk("done_pulse", 32'(done), 32'd1);
            chk("done_stall", 32'(stall), 32'd0);
            chk("done_req", 32'(mem_req), 32'd0);
            chk("load_data", load_data, v.ld_data);
        end else begin
            @(negedge clk);
            chk("misaligned", 32'(misaligned), 32'(v.kind == 1));
            chk("illegal", 32'(illegal), 32'(v.kind == 2));
            chk("exc_req", 32'(mem_req), 32'd0);
            chk("exc_stall", 32'(stall), 32'd0);
            chk("exc_load_data", load_data, v.ld_data);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("pulse_end_done", 32'(done), 32'd0);
        chk("pulse_end_exc", 32'({misaligned, illegal, bus_err}), 32'd0);
        chk("idle_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
    endtask

    vec_t vecs [14];

    initial begin
        vec_t r;
        int   sel;

        // ld st f3 addr sdata rdata wait kind wstrb wdata ld_data
        vecs[0]  = '{0, 1, 3'd0, 32'h1003, 32'h000000A5, 32'h0,        1, 0, 4'b1000, 32'hA5A5A5A5, 32'h00000000};
        vecs[1]  = '{1, 0, 3'd0, 32'h2002, 32'h0,        32'h12F45678, 0, 0, 4'b0000, 32'h0,        32'hFFFFFFF4};
        vecs[2]  = '{1, 0, 3'd4, 32'h2002, 32'h0,        32'h12F45678, 0, 0, 4'b0000, 32'h0,        32'h000000F4};
        vecs[3]  = '{1, 0, 3'd1, 32'h2002, 32'h0,        32'h80011234, 2, 0, 4'b0000, 32'h0,        32'hFFFF8001};
        vecs[4]  = '{0, 1, 3'd1, 32'h2002, 32'h0000BEEF, 32'h0,        0, 0, 4'b1100, 32'hBEEFBEEF, 32'hFFFF8001};
        vecs[5]  = '{1, 0, 3'd2, 32'h3001, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'hFFFF8001};
        vecs[6]  = '{1, 0, 3'd6, 32'h3000, 32'h0,        32'h0,        0, 2, 4'b0000, 32'h0,        32'hFFFF8001};
        vecs[7]  = '{1, 0, 3'd5, 32'h2000, 32'h0,        32'hCAFE9ABC, 3, 0, 4'b0000, 32'h0,        32'h00009ABC};
        vecs[8]  = '{1, 0, 3'd2, 32'h2004, 32'h0,        32'hDEADBEEF, 0, 0, 4'b0000, 32'h0,        32'hDEADBEEF};
        vecs[9]  = '{1, 1, 3'd2, 32'h0000, 32'h0,        32'h0,        0, 2, 4'b0000, 32'h0,        32'hDEADBEEF};
        vecs[10] = '{0, 1, 3'd3, 32'h0000, 32'h0,        32'h0,        0, 2, 4'b0000, 32'h0,        32'hDEADBEEF};
        vecs[11] = '{0, 1, 3'd1, 32'h2001, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'hDEADBEEF};
        vecs[12] = '{1, 0, 3'd0, 32'h2001, 32'h0,        32'h00007F00, 1, 0, 4'b0000, 32'h0,        32'h0000007F};
        vecs[13] = '{0, 1, 3'd0, 32'h1000, 32'hFFFFFF3C, 32'h0,        0, 0, 4'b0001, 32'h3C3C3C3C, 32'h0000007F};

        rst_n      = 1'b0;
        load       = 1'b0;
        store      = 1'b0;
        fun3       = 3'd0;
        addr       = 32'h0;
        store_data = 32'h0;
        mem_ready  = 1'b0;
        mem_rdata  = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_pulses", 32'({done, misaligned, illegal, bus_err}), 32'd0);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) run_op(vecs[i]);
        exp_ld = 32'h0000007F;

        // Timeout: lw with mem_ready held low.
        load  = 1'b1;
        fun3  = 3'd2;
        addr  = 32'h5000;
        @(posedge clk); #1;
        load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("to_req_held", 32'(mem_req), 32'd1);
            chk("to_no_err_yet", 32'(bus_err), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("to_req_drop", 32'(mem_req), 32'd0);
        chk("to_bus_err", 32'(bus_err), 32'd1);
        chk("to_no_done", 32'(done), 32'd0);
        chk("to_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("to_err_pulse", 32'(bus_err), 32'd0);
        chk("to_load_data", load_data, exp_ld);
        @(posedge clk); #1;

        // Reset taken mid-access abandons the transaction.
        load = 1'b1;
        fun3 = 3'd2;
        addr = 32'h6000;
        @(posedge clk); #1;
        load = 1'b0;
        @(negedge clk);
        chk("rm_req", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rm_quiet", 32'({mem_req, stall, done, bus_err}), 32'd0);
            @(posedge clk); #1;
        end
        exp_ld = 32'h0;
        r = '{0, 1, 3'd2, 32'h4000, 32'h13579BDF, 32'h0, 1, 0, 4'b1111, 32'h13579BDF, 32'h0};
        run_op(r);

        // Randomized operations against the model.
        for (int n = 0; n < 80; n++) begin
            sel     = $urandom_range(0, 9);
            r.ld    = (sel <= 5);
            r.st    = (sel == 0) || (sel >= 6);
            r.f3    = 3'($urandom_range(0, 7));
            r.addr  = $urandom;
            r.sdata = $urandom;
            r.rdata = $urandom;
            r.wait_n = $urandom_range(0, 3);
            r.kind  = model_kind(r.ld, r.st, r.f3, r.addr);
            r.wstrb = (r.kind == 0 && r.st) ? model_wstrb(r.f3, r.addr) : 4'b0000;
            r.wdata = model_wdata(r.f3, r.sdata);
            if (r.kind == 0 && r.ld) exp_ld = model_load(r.f3, r.addr, r.rdata);
            r.ld_data = exp_ld;
            run_op(r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory access stage downstream of the control decoder in the RV32I core.
- Consumes the decoded Load/Store strobes, fun3, the ALU-computed effective address and the rs2 store data.
- Runs a valid/ready transaction to data memory, generates byte strobes and replicated write data, and returns an aligned, sign/zero-extended load result to writeback.
- Asserts stall to hold the PC and instruction while an access is outstanding.

Parameters:
- TIMEOUT, 255: maximum cycles to wait for mem_ready before aborting with bus_err; 0 disables the timeout.
- ADDR_W, 32: effective address width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous reset, active-low
- load  in  1  decoded load strobe
- store  in  1  decoded store strobe
- fun3  in  3  instruction funct3 (access size and signedness)
- addr  in  ADDR_W  effective address from ALU
- store_data  in  32  rs2 value
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2], 2'b00})
- mem_wdata  out  32  lane-replicated write data
- mem_wstrb  out  4  byte enables (0000 on reads)
- mem_ready  in  1  memory accepts / completes request
- mem_rdata  in  32  read data, valid while mem_ready=1 on a read
- stall  out  1  hold PC/instruction
- load_data  out  32  extended load result
- done  out  1  one-cycle completion pulse; load_data valid in this cycle
- misaligned  out  1  one-cycle misaligned-access pulse
- illegal  out  1  one-cycle unsupported-op pulse
- bus_err  out  1  one-cycle timeout pulse

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; mem_req, mem_we, mem_wstrb, done, misaligned, illegal, bus_err, load_data, and the timeout counter all go to 0. A reset taken mid-transaction abandons it: no done and no bus_err.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No load/store: stay in IDLE, stall=0.
  - Valid op: register the access fields, set mem_req=1, go to ACCESS. stall=1 combinationally in this cycle.
  - Misaligned op (half with addr[0]=1, word with addr[1:0]!=0): misaligned=1 for the next cycle, no request, stall=0, stay in IDLE.
  - Illegal op (load fun3 in {011, 110, 111}; store fun3 >= 011; load and store both high): illegal=1 for the next cycle, no request, stall=0.
- ACCESS:
  - mem_req and all mem_* outputs are held stable until the cycle with mem_ready=1. stall=1.
  - On mem_ready: drop mem_req, capture the extended load_data (reads only), go to DONE.
  - Counter increments each waiting cycle. If TIMEOUT!=0 and the counter reaches TIMEOUT: drop mem_req, pulse bus_err, go to IDLE.
  - mem_ready is sampled only while mem_req=1.
- DONE: done=1, stall=0 (the PC advances at this edge), return to IDLE. The next instruction is evaluated in the following cycle, so there is no double issue.
- Minimum latency: issue cycle, at least one ACCESS cycle, then DONE. With mem_ready=1 immediately, stall is high for 2 cycles.
- Store encoding (wdata/wstrb):
  - sb: wdata = byte replicated x4; wstrb = 0001 << addr[1:0].
  - sh: wdata = half replicated x2; wstrb = 0011 << {addr[1], 1'b0}.
  - sw: wdata = store_data; wstrb = 1111.
- Load extraction: select the lane from rdata using addr[1:0]. lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
- load_data holds its value until the next load completes. Stores leave load_data unchanged.

Test Plan:
- sb: addr=0x1003, store_data=0x000000A5, mem_ready after 2 cycles -> mem_addr=0x1000, wdata=0xA5A5A5A5, wstrb=1000, mem_we=1; stall high for 3 cycles; done pulse; load_data unchanged.
- lb/lbu: addr=0x2002, mem_rdata=0x12F45678, ready immediately -> lb gives load_data=0xFFFFFFF4; lbu gives 0x000000F4; stall high for exactly 2 cycles.
- lh: addr=0x2002, rdata=0x8001_xxxx -> 0xFFFF8001. sh at addr=0x2002, data=0x0000BEEF -> wdata=0xBEEFBEEF, wstrb=1100.
- lw at addr=0x3001 -> misaligned=1 for one cycle, mem_req never asserted, stall=0. load with fun3=110 -> illegal pulse, no request.
- TIMEOUT=4, mem_ready held 0 -> mem_req drops after 4 waiting cycles, bus_err pulses once, no done, FSM back in IDLE.
- rst_n=0 during ACCESS -> next cycle mem_req=0, stall=0, no done or bus_err; a subsequent sw at 0x4000 completes normally with wstrb=1111.
